// File: rtl/zynet_pkg.sv
// Shared types for the zynet front end: sample word width, word type and the
// input window buffer FSM states.
package zynet_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/window_shift_reg.sv
// Row storage for the input window: shifts toward row 0 on enable, new row
// enters at the top, all rows visible in parallel.
module window_shift_reg #(
  parameter int DEPTH = 5,
  parameter int ROW_W = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_shift_en,
  input  logic [ROW_W-1:0]            i_row,
  output logic [DEPTH-1:0][ROW_W-1:0] o_rows
);

  logic [DEPTH-1:0][ROW_W-1:0] r_rows;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rows <= '0;
    end else if (i_shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_rows[i] <= r_rows[i+1];
      end
      r_rows[DEPTH-1] <= i_row;
    end
  end

  assign o_rows = r_rows;

endmodule

// File: rtl/input_window_buffer.sv
// Sliding window over a frame of tx/rx sample pairs; each accepted pair
// produces one KERNEL_HEIGHT-deep window once the window has filled.
module input_window_buffer #(
  parameter int NUM_SAMPLES   = 60,
  parameter int KERNEL_HEIGHT = 5,
  parameter int KERNEL_WIDTH  = 2,
  parameter int WORD_SIZE     = zynet_pkg::WORD_SIZE
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_i,
  input  logic                                                   start_i,
  input  logic [WORD_SIZE-1:0]                                   tx_data_i,
  input  logic [WORD_SIZE-1:0]                                   rx_data_i,
  input  logic                                                   valid_i,
  output logic                                                   ready_o,
  output logic [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] data_o,
  output logic                                                   valid_o,
  input  logic                                                   yumi_i,
  output logic                                                   last_o,
  output logic [$clog2(NUM_SAMPLES)-1:0]                         win_idx_o
);

  import zynet_pkg::*;

  localparam int ROW_W = KERNEL_WIDTH * WORD_SIZE;
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int IDX_W = $clog2(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] KH_C = CNT_W'(KERNEL_HEIGHT);
  localparam logic [CNT_W-1:0] NS_C = CNT_W'(NUM_SAMPLES);

  state_t                                   r_state;
  logic [CNT_W-1:0]                         r_cnt;
  logic [CNT_W-1:0]                         w_cnt_nxt;
  logic                                     w_accept;
  logic                                     w_consume;
  logic [KERNEL_WIDTH-1:0][WORD_SIZE-1:0]   w_row;
  logic [KERNEL_HEIGHT-1:0][ROW_W-1:0]      w_rows;

  // yumi_i may free the output slot in the same cycle a new pair arrives
  assign ready_o   = (r_state == LOAD) && (!valid_o || yumi_i);
  assign w_accept  = valid_i && ready_o;
  assign w_consume = yumi_i && valid_o;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  always_comb begin
    w_row    = '0;
    w_row[0] = tx_data_i;
    w_row[1] = rx_data_i;
  end

  window_shift_reg #(
    .DEPTH (KERNEL_HEIGHT),
    .ROW_W (ROW_W)
  ) u_rows (
    .i_clk      (clk_i),
    .i_reset    (reset_i),
    .i_shift_en (w_accept),
    .i_row      (w_row),
    .o_rows     (w_rows)
  );

  assign data_o = w_rows;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      win_idx_o <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state   <= LOAD;
            r_cnt     <= '0;
            win_idx_o <= '0;
          end
        end
        LOAD: begin
          if (w_consume) begin
            win_idx_o <= win_idx_o + IDX_W'(1);
          end
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt >= KH_C) begin
              valid_o <= 1'b1;
            end
            if (w_cnt_nxt == NS_C) begin
              r_state <= DRAIN;
              last_o  <= 1'b1;
            end
          end else if (w_consume) begin
            valid_o <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_consume) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
